// File: rtl/conv_pkg.sv
// Shared types and window slot layout for the 3x3 RGB444 window generator.
// Pixel packing inside a row bus: [11:0]=left, [23:12]=centre, [35:24]=right.
package conv_pkg;

    localparam int PIX_W = 12;

    typedef logic [PIX_W-1:0]   pix_t;
    typedef logic [3*PIX_W-1:0] win_row_t;

    localparam int SLOT_LEFT   = 0;
    localparam int SLOT_CENTRE = 1;
    localparam int SLOT_RIGHT  = 2;

    function automatic int slot_ofs(input int slot);
        return slot * PIX_W;
    endfunction

    localparam int LEFT   = slot_ofs(SLOT_LEFT);
    localparam int CENTRE = slot_ofs(SLOT_CENTRE);
    localparam int RIGHT  = slot_ofs(SLOT_RIGHT);

endpackage

// File: rtl/conv_line_buf.sv
// One image-row line buffer: single write port, asynchronous read at the same address.
// Contents are not reset; every location is rewritten before it is ever used in a window.
module conv_line_buf
    import conv_pkg::*;
#(
    parameter int DEPTH  = 160,
    parameter int DATA_W = PIX_W,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    assign rdata = mem_q[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Sliding 3x3 window generator over a raster pixel stream, registered valid/ready output.
// Optional CONV_WIN_STALL_CNT_EN adds a saturating count of output-stall cycles (stall_cnt).
module conv_window_gen #(
    parameter int IMG_W = 160,
    parameter int IMG_H = 120,
    parameter int PIX_W = conv_pkg::PIX_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sof,
    input  logic [PIX_W-1:0]   pix_in,
    input  logic               pix_valid,
    output logic               pix_ready,
    output logic [3*PIX_W-1:0] win_row0,
    output logic [3*PIX_W-1:0] win_row1,
    output logic [3*PIX_W-1:0] win_row2,
    output logic               win_valid,
    input  logic               win_ready,
`ifdef CONV_WIN_STALL_CNT_EN
    output logic [31:0]        stall_cnt,
`endif
    output logic               frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    logic [CW-1:0]        col_q, col_d, col_cur;
    logic [RW-1:0]        row_q, row_d, row_cur;
    logic [3*PIX_W-1:0]   top_sr_q, top_sr_d;
    logic [3*PIX_W-1:0]   mid_sr_q, mid_sr_d;
    logic [3*PIX_W-1:0]   bot_sr_q, bot_sr_d;
    logic [3*PIX_W-1:0]   win_row0_q, win_row0_d;
    logic [3*PIX_W-1:0]   win_row1_q, win_row1_d;
    logic [3*PIX_W-1:0]   win_row2_q, win_row2_d;
    logic                 win_valid_q, win_valid_d;
    logic                 frame_done_q, frame_done_d;
    logic [PIX_W-1:0]     lb0_rd, lb1_rd;
    logic                 accept;
    logic                 last_col, last_row;

    assign pix_ready = ~win_valid_q | win_ready;
    assign accept    = pix_valid & pix_ready;

    conv_line_buf #(.DEPTH(IMG_W), .DATA_W(PIX_W), .AW(CW)) u_lb0 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_cur),
        .wdata (pix_in),
        .rdata (lb0_rd)
    );

    conv_line_buf #(.DEPTH(IMG_W), .DATA_W(PIX_W), .AW(CW)) u_lb1 (
        .clk   (clk),
        .we    (accept),
        .addr  (col_cur),
        .wdata (lb0_rd),
        .rdata (lb1_rd)
    );

    always_comb begin
        // A pixel arriving together with sof is position (0,0) of the new frame.
        col_cur      = sof ? '0 : col_q;
        row_cur      = sof ? '0 : row_q;
        last_col     = (col_cur == CW'(IMG_W - 1));
        last_row     = (row_cur == RW'(IMG_H - 1));
        col_d        = col_cur;
        row_d        = row_cur;
        top_sr_d     = top_sr_q;
        mid_sr_d     = mid_sr_q;
        bot_sr_d     = bot_sr_q;
        win_row0_d   = win_row0_q;
        win_row1_d   = win_row1_q;
        win_row2_d   = win_row2_q;
        win_valid_d  = win_valid_q & ~win_ready;
        frame_done_d = 1'b0;
        if (accept) begin
            top_sr_d = {lb1_rd, top_sr_q[3*PIX_W-1:PIX_W]};
            mid_sr_d = {lb0_rd, mid_sr_q[3*PIX_W-1:PIX_W]};
            bot_sr_d = {pix_in, bot_sr_q[3*PIX_W-1:PIX_W]};
            if (last_col) begin
                col_d        = '0;
                row_d        = last_row ? '0 : row_cur + RW'(1);
                frame_done_d = last_row;
            end else begin
                col_d = col_cur + CW'(1);
            end
            // Shift registers carry stale pixels across a row wrap until col reaches 2.
            if (row_cur >= RW'(2) && col_cur >= CW'(2)) begin
                win_row0_d  = top_sr_d;
                win_row1_d  = mid_sr_d;
                win_row2_d  = bot_sr_d;
                win_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            top_sr_q     <= '0;
            mid_sr_q     <= '0;
            bot_sr_q     <= '0;
            win_row0_q   <= '0;
            win_row1_q   <= '0;
            win_row2_q   <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            top_sr_q     <= top_sr_d;
            mid_sr_q     <= mid_sr_d;
            bot_sr_q     <= bot_sr_d;
            win_row0_q   <= win_row0_d;
            win_row1_q   <= win_row1_d;
            win_row2_q   <= win_row2_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign win_row0   = win_row0_q;
    assign win_row1   = win_row1_q;
    assign win_row2   = win_row2_q;
    assign win_valid  = win_valid_q;
    assign frame_done = frame_done_q;

`ifdef CONV_WIN_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (sof) begin
            stall_cnt_d = '0;
        end else if (win_valid_q && !win_ready && stall_cnt_q != 32'hFFFF_FFFF) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image; windows are checked against a pixel-array model.
// Build with CONV_WIN_STALL_CNT_EN defined to also cover stall_cnt.
module tb_conv_window_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sof = 1'b0;
    logic [11:0]  pix_in = '0;
    logic         pix_valid = 1'b0;
    logic         pix_ready;
    logic [35:0]  win_row0, win_row1, win_row2;
    logic         win_valid;
    logic         win_ready = 1'b1;
    logic         frame_done;
`ifdef CONV_WIN_STALL_CNT_EN
    logic [31:0]  stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    conv_window_gen #(.IMG_W(4), .IMG_H(4), .PIX_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .sof        (sof),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .win_row0   (win_row0),
        .win_row1   (win_row1),
        .win_row2   (win_row2),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
`ifdef CONV_WIN_STALL_CNT_EN
        .stall_cnt  (stall_cnt),
`endif
        .frame_done (frame_done)
    );

    logic [11:0]  img [0:7][0:3][0:3];
    logic [107:0] win_q [$];
    int           fd_cnt = 0;
    int           acc_cnt = 0;
    int           first_win_acc = -1;
    logic [11:0]  fd_pix = '0;
    logic [11:0]  last_pix = '0;
    logic         wv_prev = 1'b0;

    always @(negedge clk) begin
        if (frame_done) begin
            fd_cnt++;
            fd_pix = last_pix;
        end
        if (win_valid && !wv_prev && first_win_acc < 0) first_win_acc = acc_cnt;
        if (win_valid && win_ready) win_q.push_back({win_row0, win_row1, win_row2});
        if (pix_valid && pix_ready) begin
            acc_cnt++;
            last_pix = pix_in;
        end
        wv_prev = win_valid;
    end

    function automatic logic [107:0] exp_win(input int f, input int r, input int c);
        return {img[f][r-2][c], img[f][r-2][c-1], img[f][r-2][c-2],
                img[f][r-1][c], img[f][r-1][c-1], img[f][r-1][c-2],
                img[f][r][c],   img[f][r][c-1],   img[f][r][c-2]};
    endfunction

    task automatic clr();
        win_q.delete();
        fd_cnt = 0;
        acc_cnt = 0;
        first_win_acc = -1;
    endtask

    task automatic do_reset();
        rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; win_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        clr();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [11:0] p, input logic s);
        int n;
        n = 0;
        pix_in = p; pix_valid = 1'b1; sof = s;
        @(negedge clk);
        while (!pix_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!pix_ready) begin
            checks++; errors++;
            $display("FAIL push_timeout pixel=%h never accepted", p);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0; sof = 1'b0;
    endtask

    task automatic fill_seq(input int f, input int base);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                img[f][r][c] = 12'(base + r*4 + c);
    endtask

    task automatic push_frame(input int f);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                push(img[f][r][c], 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; pix_valid = 1'b0; sof = 1'b0; win_ready = 1'b1;
        idle(2);
        checks += 6;
        if (win_valid !== 1'b0) begin errors++; $display("FAIL reset_win_valid got=%b exp=0", win_valid); end
        if (win_row0 !== 36'h0) begin errors++; $display("FAIL reset_win_row0 got=%h exp=0", win_row0); end
        if (win_row1 !== 36'h0) begin errors++; $display("FAIL reset_win_row1 got=%h exp=0", win_row1); end
        if (win_row2 !== 36'h0) begin errors++; $display("FAIL reset_win_row2 got=%h exp=0", win_row2); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
        if (pix_ready !== 1'b1) begin errors++; $display("FAIL reset_pix_ready got=%b exp=1", pix_ready); end
`ifdef CONV_WIN_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
        #1 rst = 1'b0;
        clr();
    endtask

    task automatic test_single_frame();
        do_reset();
        fill_seq(0, 1);
        push_frame(0);
        idle(4);
        checks += 3;
        if (win_q.size() != 4) begin errors++; $display("FAIL single_count got=%0d exp=4", win_q.size()); end
        if (win_q.size() > 0 && win_q[0] !== {36'h003002001, 36'h007006005, 36'h00B00A009}) begin
            errors++; $display("FAIL single_first_window got=%h exp=%h", win_q[0],
                               {36'h003002001, 36'h007006005, 36'h00B00A009});
        end
        for (int k = 0; k < 4 && k < win_q.size(); k++) begin
            checks++;
            if (win_q[k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin
                errors++; $display("FAIL single_window%0d got=%h exp=%h", k, win_q[k], exp_win(0, 2 + k/2, 2 + k%2));
            end
        end
        if (fd_cnt != 1) begin errors++; $display("FAIL single_frame_done_count got=%0d exp=1", fd_cnt); end
        checks++;
        if (fd_pix !== 12'h010) begin errors++; $display("FAIL single_frame_done_pixel got=%h exp=010", fd_pix); end
    endtask

    task automatic test_stall();
        int n;
        do_reset();
        fill_seq(1, 1);
        fork
            push_frame(1);
            begin
                n = 0;
                do begin
                    @(posedge clk); #1; n++;
                end while (!win_valid && n < 200);
                checks++;
                if (!win_valid) begin errors++; $display("FAIL stall_wait_valid got=0 exp=1"); end
                win_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(posedge clk); #1;
                    checks += 3;
                    if (win_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid%0d got=%b exp=1", i, win_valid); end
                    if (pix_ready !== 1'b0) begin errors++; $display("FAIL stall_pix_ready%0d got=%b exp=0", i, pix_ready); end
                    if ({win_row0, win_row1, win_row2} !== exp_win(1, 2, 2)) begin
                        errors++; $display("FAIL stall_hold_window%0d got=%h exp=%h", i,
                                           {win_row0, win_row1, win_row2}, exp_win(1, 2, 2));
                    end
                end
`ifdef CONV_WIN_STALL_CNT_EN
                checks++;
                if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stall_cnt_during got=%0d exp=5", stall_cnt); end
`endif
                win_ready = 1'b1;
            end
        join
        idle(4);
        checks++;
        if (win_q.size() != 4) begin errors++; $display("FAIL stall_count got=%0d exp=4", win_q.size()); end
        for (int k = 0; k < 4 && k < win_q.size(); k++) begin
            checks++;
            if (win_q[k] !== exp_win(1, 2 + k/2, 2 + k%2)) begin
                errors++; $display("FAIL stall_window%0d got=%h exp=%h", k, win_q[k], exp_win(1, 2 + k/2, 2 + k%2));
            end
        end
`ifdef CONV_WIN_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd5) begin errors++; $display("FAIL stall_cnt_final got=%0d exp=5", stall_cnt); end
`endif
    endtask

    task automatic test_back_to_back();
        do_reset();
        fill_seq(0, 1);
        push_frame(0);
        push_frame(0);
        idle(4);
        checks += 2;
        if (win_q.size() != 8) begin errors++; $display("FAIL b2b_count got=%0d exp=8", win_q.size()); end
        if (fd_cnt != 2) begin errors++; $display("FAIL b2b_frame_done_count got=%0d exp=2", fd_cnt); end
        for (int k = 0; k < 8 && k < win_q.size(); k++) begin
            checks++;
            if (win_q[k] !== exp_win(0, 2 + (k%4)/2, 2 + k%2)) begin
                errors++; $display("FAIL b2b_window%0d got=%h exp=%h", k, win_q[k], exp_win(0, 2 + (k%4)/2, 2 + k%2));
            end
        end
    endtask

    task automatic test_sof();
        do_reset();
        fill_seq(5, 'h0AA);
        for (int i = 0; i < 6; i++) push(12'(12'h101 + i), 1'b0);
        push(img[5][0][0], 1'b1);
        for (int p = 1; p < 16; p++) push(img[5][p/4][p%4], 1'b0);
        idle(4);
        checks += 4;
        if (first_win_acc != 17) begin errors++; $display("FAIL sof_first_window_after got=%0d exp=17 accepts", first_win_acc); end
        if (win_q.size() != 4) begin errors++; $display("FAIL sof_count got=%0d exp=4", win_q.size()); end
        if (fd_cnt != 1) begin errors++; $display("FAIL sof_frame_done_count got=%0d exp=1", fd_cnt); end
        if (fd_pix !== 12'h0B9) begin errors++; $display("FAIL sof_frame_done_pixel got=%h exp=0b9", fd_pix); end
        for (int k = 0; k < 4 && k < win_q.size(); k++) begin
            checks++;
            if (win_q[k] !== exp_win(5, 2 + k/2, 2 + k%2)) begin
                errors++; $display("FAIL sof_window%0d got=%h exp=%h", k, win_q[k], exp_win(5, 2 + k/2, 2 + k%2));
            end
        end
    endtask

    task automatic test_rst_mid();
        do_reset();
        fill_seq(0, 1);
        win_ready = 1'b0;
        for (int p = 0; p < 11; p++) push(img[0][p/4][p%4], 1'b0);
        checks += 2;
        if (win_valid !== 1'b1) begin errors++; $display("FAIL rstmid_pre_valid got=%b exp=1", win_valid); end
        if ({win_row0, win_row1, win_row2} !== exp_win(0, 2, 2)) begin
            errors++; $display("FAIL rstmid_pre_window got=%h exp=%h", {win_row0, win_row1, win_row2}, exp_win(0, 2, 2));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        checks += 5;
        if (win_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got=%b exp=0", win_valid); end
        if (win_row0 !== 36'h0) begin errors++; $display("FAIL rstmid_row0 got=%h exp=0", win_row0); end
        if (win_row1 !== 36'h0) begin errors++; $display("FAIL rstmid_row1 got=%h exp=0", win_row1); end
        if (win_row2 !== 36'h0) begin errors++; $display("FAIL rstmid_row2 got=%h exp=0", win_row2); end
        if (frame_done !== 1'b0) begin errors++; $display("FAIL rstmid_frame_done got=%b exp=0", frame_done); end
`ifdef CONV_WIN_STALL_CNT_EN
        checks++;
        if (stall_cnt !== 32'd0) begin errors++; $display("FAIL rstmid_stall_cnt got=%0d exp=0", stall_cnt); end
`endif
        rst = 1'b0;
        win_ready = 1'b1;
        clr();
        push_frame(0);
        idle(4);
        checks += 2;
        if (win_q.size() != 4) begin errors++; $display("FAIL rstmid_count got=%0d exp=4", win_q.size()); end
        if (fd_cnt != 1) begin errors++; $display("FAIL rstmid_frame_done_count got=%0d exp=1", fd_cnt); end
        for (int k = 0; k < 4 && k < win_q.size(); k++) begin
            checks++;
            if (win_q[k] !== exp_win(0, 2 + k/2, 2 + k%2)) begin
                errors++; $display("FAIL rstmid_window%0d got=%h exp=%h", k, win_q[k], exp_win(0, 2 + k/2, 2 + k%2));
            end
        end
    endtask

    task automatic test_random();
        bit done;
        do_reset();
        done = 1'b0;
        for (int f = 2; f < 5; f++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    img[f][r][c] = 12'($urandom_range(0, 4095));
        fork
            begin
                for (int f = 2; f < 5; f++)
                    for (int p = 0; p < 16; p++) begin
                        idle($urandom_range(0, 2));
                        push(img[f][p/4][p%4], 1'b0);
                    end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    win_ready = ($urandom_range(0, 1) == 1);
                end
                win_ready = 1'b1;
            end
        join
        idle(4);
        checks += 2;
        if (win_q.size() != 12) begin errors++; $display("FAIL random_count got=%0d exp=12", win_q.size()); end
        if (fd_cnt != 3) begin errors++; $display("FAIL random_frame_done_count got=%0d exp=3", fd_cnt); end
        for (int k = 0; k < 12 && k < win_q.size(); k++) begin
            checks++;
            if (win_q[k] !== exp_win(2 + k/4, 2 + (k%4)/2, 2 + k%2)) begin
                errors++; $display("FAIL random_window%0d got=%h exp=%h", k, win_q[k],
                                   exp_win(2 + k/4, 2 + (k%4)/2, 2 + k%2));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_stall();
        test_back_to_back();
        test_sof();
        test_rst_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
